fifo_wptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the team's dual-clock FIFO (256 entries at default width). Runs entirely on the write clock. It owns the binary and Gray write pointers and the RAM write address. It brings the read side's Gray pointer into the write domain through its own synchronizer and derives full, almost-full, occupancy and sticky-overflow status. Gray/binary conversion uses `bin2gray`/`gray2bin` from the `conversionFunctions` package.

---
 rtl/conversionFunctions.sv | 27 ++
 rtl/fifo_wptr_full_if.sv | 28 ++
 rtl/sync_nff.sv | 31 +++
 rtl/fifo_wptr_full.sv | 96 +++++++++
 tb/tb_fifo_wptr_full.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/conversionFunctions.sv
// Shared pointer-width constants and Gray/binary conversion helpers for the
// dual-clock FIFO. Used by the write-side and read-side pointer blocks and
// by the RAM.
package conversionFunctions;

  // Pointer width including the wrap bit.
  localparam int WIDTH  = 9;
  // RAM address width and FIFO depth.
  localparam int ADDR_W = WIDTH - 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  // Binary to reflected Gray code.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down).
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the dual-clock FIFO: push handshake, RAM write address,
// the Gray pointer crossing to the read domain and write-side status.
interface fifo_wptr_full_if #(
  parameter int WIDTH = conversionFunctions::WIDTH
);
  logic             wr_en;
  logic             clr_overflow;
  logic [WIDTH-1:0] rd_ptr_gray_async;
  logic             wr_accept;
  logic [WIDTH-2:0] wr_addr;
  logic [WIDTH-1:0] wr_ptr_gray;
  logic             full;
  logic             almost_full;
  logic [WIDTH-1:0] level;
  logic             overflow;

  // Producer / RAM side.
  modport master (
    output wr_en, clr_overflow, rd_ptr_gray_async,
    input  wr_accept, wr_addr, wr_ptr_gray, full, almost_full, level, overflow
  );

  // Write-pointer block.
  modport slave (
    input  wr_en, clr_overflow, rd_ptr_gray_async,
    output wr_accept, wr_addr, wr_ptr_gray, full, almost_full, level, overflow
  );
endinterface

// File: rtl/sync_nff.sv
// Plain N-flop synchronizer chain. No logic between stages so every bit
// gets the full resolution time of each stage. Shared with the read side.
module sync_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag generator for the dual-clock FIFO.
// Owns the binary/Gray write pointers, synchronizes the read Gray pointer
// and derives full, almost-full, occupancy and sticky overflow. Full and
// level are pessimistic: the read pointer seen here lags the real one.
module fifo_wptr_full #(
  parameter int WIDTH        = conversionFunctions::WIDTH,
  parameter int AFULL_THRESH = 240,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  fifo_wptr_full_if.slave bus
);

  // The conversion helpers are fixed-width, so only the package width works.
  if (WIDTH != conversionFunctions::WIDTH) begin : g_bad_width
    $error("fifo_wptr_full: WIDTH must equal conversionFunctions::WIDTH");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > 2 ** (WIDTH - 1)) begin : g_bad_afull
    $error("fifo_wptr_full: AFULL_THRESH out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_wptr_full: SYNC_STAGES must be at least 2");
  end

  localparam logic [WIDTH-1:0] AFULL_W = WIDTH'(AFULL_THRESH);

  logic [WIDTH-1:0] wr_ptr_bin_q,  wr_ptr_bin_d;
  logic [WIDTH-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [WIDTH-1:0] level_q,       level_d;
  logic             full_q,        full_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q,    overflow_d;
  logic             accept;
  logic [WIDTH-1:0] rq;
  logic [WIDTH-1:0] rbin;

  sync_nff #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rd_ptr_gray_async),
    .q_o (rq)
  );

  // Next-state pointer, flag and occupancy computation.
  always_comb begin
    accept        = bus.wr_en & ~full_q;
    wr_ptr_bin_d  = wr_ptr_bin_q + WIDTH'(accept);
    wr_ptr_gray_d = conversionFunctions::bin2gray(wr_ptr_bin_d);
    rbin          = conversionFunctions::gray2bin(rq);
    // Full when the write pointer is exactly one lap ahead: in Gray code
    // that is the read pointer with its top two bits inverted.
    full_d        = (wr_ptr_gray_d == {~rq[WIDTH-1:WIDTH-2], rq[WIDTH-3:0]});
    level_d       = wr_ptr_bin_d - rbin;
    almost_full_d = (level_d >= AFULL_W);
    // A rejected push beats a simultaneous clear so no overflow is lost.
    overflow_d    = overflow_q;
    if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (bus.wr_en && full_q) begin
      overflow_d = 1'b1;
    end
  end

  // Register pointers and status; reset discards all write-side state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.wr_accept   = accept;
  assign bus.wr_addr     = wr_ptr_bin_q[WIDTH-2:0];
  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full. Stimulus queues hand-computed
// expectations tagged with the cycle they apply to; a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_fifo_wptr_full;

  localparam int W = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wptr_full_if #(.WIDTH(W)) bus ();

  fifo_wptr_full #(
    .WIDTH        (W),
    .AFULL_THRESH (240),
    .SYNC_STAGES  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {F_FULL, F_AF, F_LEVEL, F_OVF, F_GRAY, F_ADDR, F_ACC} fld_e;
  typedef struct {
    string       name;
    int          cyc;
    fld_e        fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(fld_e f);
    case (f)
      F_FULL:  return {31'b0, bus.full};
      F_AF:    return {31'b0, bus.almost_full};
      F_LEVEL: return {23'b0, bus.level};
      F_OVF:   return {31'b0, bus.overflow};
      F_GRAY:  return {23'b0, bus.wr_ptr_gray};
      F_ADDR:  return {24'b0, bus.wr_addr};
      default: return {31'b0, bus.wr_accept};
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e   = sb_q.pop_front();
      act = dut_val(e.fld);
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", e.name, cyc, act, e.val);
      end else begin
        $display("ok   %s cyc=%0d value=0x%0h", e.name, cyc, act);
      end
    end
  end

  task automatic chk(input string n, input fld_e f, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.cyc  = cyc;
    e.fld  = f;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] gray_of(input int unsigned n);
    logic [8:0] b;
    b = n[8:0];
    return b ^ {1'b0, b[8:1]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned wcount;
    int unsigned rcount;
    int          lag;

    // Reset with wr_en held high.
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.clr_overflow = 1'b0;
    bus.rd_ptr_gray_async = '0;
    tick();
    tick();
    chk("rst_full",  F_FULL,  0);
    chk("rst_af",    F_AF,    0);
    chk("rst_level", F_LEVEL, 0);
    chk("rst_ovf",   F_OVF,   0);
    chk("rst_addr",  F_ADDR,  0);
    chk("rst_gray",  F_GRAY,  0);

    // Fill to full with the read pointer parked at 0.
    rst = 1'b0;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk("fill_addr", F_ADDR, 32'(i));
      chk("fill_acc",  F_ACC,  1);
      tick();
      if (i + 1 == 239) begin
        chk("af_239_lo", F_AF,    0);
        chk("lvl_239",   F_LEVEL, 239);
      end
      if (i + 1 == 240) begin
        chk("af_240_hi", F_AF,    1);
        chk("lvl_240",   F_LEVEL, 240);
      end
      if (i + 1 == 255) begin
        chk("full_255_lo", F_FULL, 0);
      end
    end
    chk("full_256",  F_FULL,  1);
    chk("level_256", F_LEVEL, 32'h100);
    chk("gray_256",  F_GRAY,  32'h180);
    // 257th push is refused.
    chk("p257_acc",  F_ACC,   0);
    chk("p257_addr", F_ADDR,  0);
    tick();
    chk("p257_ovf",  F_OVF,   1);
    chk("p257_full", F_FULL,  1);
    chk("p257_addr2", F_ADDR, 0);

    // Release one entry from the read side.
    bus.wr_en = 1'b0;
    bus.rd_ptr_gray_async = 9'h001;
    tick();
    tick();
    chk("rel_full_c2", F_FULL, 1);
    tick();
    chk("rel_full_c3",  F_FULL,  0);
    chk("rel_level_c3", F_LEVEL, 255);
    chk("rel_af_c3",    F_AF,    1);
    bus.wr_en = 1'b1;
    chk("rel_acc",  F_ACC,  1);
    chk("rel_addr", F_ADDR, 0);
    tick();
    bus.wr_en = 1'b0;
    chk("refill_full",  F_FULL,  1);
    chk("refill_level", F_LEVEL, 256);
    chk("refill_gray",  F_GRAY,  32'h181);
    chk("ovf_sticky",   F_OVF,   1);

    // Sticky overflow: clear, then set-wins-over-clear, then clear again.
    bus.clr_overflow = 1'b1;
    tick();
    chk("clr_ovf", F_OVF, 0);
    bus.wr_en = 1'b1;
    chk("setclr_acc", F_ACC, 0);
    tick();
    chk("set_wins", F_OVF, 1);
    bus.wr_en = 1'b0;
    tick();
    chk("clr_again", F_OVF, 0);
    bus.clr_overflow = 1'b0;

    // Mid-fill reset.
    bus.rd_ptr_gray_async = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wr_en = 1'b1;
    repeat (100) tick();
    bus.wr_en = 1'b0;
    chk("mid_level100", F_LEVEL, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_level", F_LEVEL, 0);
    chk("mid_rst_full",  F_FULL,  0);
    chk("mid_rst_gray",  F_GRAY,  0);
    chk("mid_rst_ovf",   F_OVF,   0);

    // Wrap: 600 pushes with the read pointer trailing by at most 10.
    wcount = 0;
    rcount = 0;
    for (int i = 0; i < 600; i++) begin
      bus.rd_ptr_gray_async = gray_of(rcount);
      bus.wr_en = 1'b1;
      chk("wrap_addr", F_ADDR, 32'(wcount % 256));
      chk("wrap_acc",  F_ACC,  1);
      tick();
      wcount++;
      chk("wrap_gray", F_GRAY, 32'(gray_of(wcount)));
      chk("wrap_full", F_FULL, 0);
      lag = 1 + (i % 10);
      rcount = (wcount > 32'(lag)) ? wcount - 32'(lag) : 0;
    end
    bus.wr_en = 1'b0;
    bus.rd_ptr_gray_async = gray_of(wcount);
    tick();
    tick();
    tick();
    chk("drain_level", F_LEVEL, 0);
    chk("drain_af",    F_AF,    0);
    chk("drain_gray",  F_GRAY,  32'(gray_of(600)));

    tick();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
